// File: rtl/board_rev1_clock_monitor.sv
// rtl/board_rev1_clock_monitor.sv - windowed edge-count monitor that qualifies a toggle-encoded clock
// Locks after GOOD_WINDOWS consecutive in-range windows; a locked clock leaving range sets sticky FAULT.
module board_rev1_clock_monitor #(
  parameter int GATE_CYCLES  = 1074,
  parameter int EXP_MIN      = 1300,
  parameter int EXP_MAX      = 1390,
  parameter int GOOD_WINDOWS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MON_TOGGLE,
  input  logic        ENABLE,
  input  logic        FAULT_CLR,
  output logic        READY,
  output logic        FAULT,
  output logic [15:0] COUNT,
  output logic        COUNT_VALID
);

  localparam logic [15:0] GATE_LAST   = 16'(GATE_CYCLES - 1);
  localparam logic [15:0] EXP_MIN_16  = 16'(EXP_MIN);
  localparam logic [15:0] EXP_MAX_16  = 16'(EXP_MAX);
  localparam logic [3:0]  GOOD_TARGET = 4'(GOOD_WINDOWS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        hist;
  logic [15:0] gate_cnt;
  logic [15:0] edge_cnt;
  logic [3:0]  good_cnt;

  logic        mon_edge;
  logic [15:0] total;
  logic        in_range;
  logic        window_done;
  logic        fault_set;
  logic [3:0]  good_next;

  // The edge seen in a window's last cycle still belongs to that window.
  always_comb begin
    mon_edge    = sync2 ^ hist;
    total       = (edge_cnt == 16'hFFFF) ? 16'hFFFF : edge_cnt + {15'd0, mon_edge};
    in_range    = (total >= EXP_MIN_16) && (total <= EXP_MAX_16);
    window_done = (state != IDLE) && ENABLE && (gate_cnt == GATE_LAST);
    fault_set   = window_done && (state == LOCKED) && !in_range;
    good_next   = good_cnt + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      hist        <= 1'b0;
      gate_cnt    <= 16'd0;
      edge_cnt    <= 16'd0;
      good_cnt    <= 4'd0;
      READY       <= 1'b0;
      FAULT       <= 1'b0;
      COUNT       <= 16'd0;
      COUNT_VALID <= 1'b0;
    end else begin
      sync1       <= MON_TOGGLE;
      sync2       <= sync1;
      hist        <= sync2;
      COUNT_VALID <= 1'b0;

      // Later assignment lets a same-cycle fault win over the clear.
      if (FAULT_CLR) FAULT <= 1'b0;
      if (fault_set) FAULT <= 1'b1;

      if (!ENABLE) begin
        state    <= IDLE;
        READY    <= 1'b0;
        gate_cnt <= 16'd0;
        edge_cnt <= 16'd0;
        good_cnt <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            state    <= ACQUIRE;
            gate_cnt <= 16'd0;
            edge_cnt <= 16'd0;
            good_cnt <= 4'd0;
          end
          ACQUIRE, LOCKED: begin
            if (window_done) begin
              gate_cnt    <= 16'd0;
              edge_cnt    <= 16'd0;
              COUNT       <= total;
              COUNT_VALID <= 1'b1;
              if (in_range) begin
                if (state == ACQUIRE) begin
                  good_cnt <= good_next;
                  if (good_next == GOOD_TARGET) begin
                    state <= LOCKED;
                    READY <= 1'b1;
                  end
                end
              end else begin
                good_cnt <= 4'd0;
                state    <= ACQUIRE;
                READY    <= 1'b0;
              end
            end else begin
              gate_cnt <= gate_cnt + 16'd1;
              edge_cnt <= total;
            end
          end
          default: begin
            state <= IDLE;
            READY <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_rev1_clock_monitor.sv
// tb/tb_board_rev1_clock_monitor.sv - directed self-checking bench for board_rev1_clock_monitor
module tb_board_rev1_clock_monitor;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        mon = 1'b0;
  logic        en = 1'b0;
  logic        fclr = 1'b0;
  logic        READY;
  logic        FAULT;
  logic [15:0] COUNT;
  logic        COUNT_VALID;

  logic        sat_mon = 1'b0;
  logic        sat_en = 1'b0;
  logic        sat_ready;
  logic        sat_fault;
  logic [15:0] sat_count;
  logic        sat_cv;

  int n_cmp = 0;
  int n_bad = 0;
  int rel = 0;
  int per = 0;
  int ph = 0;
  logic sat_tog = 1'b0;

  board_rev1_clock_monitor #(
    .GATE_CYCLES(100), .EXP_MIN(18), .EXP_MAX(22), .GOOD_WINDOWS(2)
  ) u_dut (
    .CLK(CLK), .RESET(RESET), .MON_TOGGLE(mon), .ENABLE(en), .FAULT_CLR(fclr),
    .READY(READY), .FAULT(FAULT), .COUNT(COUNT), .COUNT_VALID(COUNT_VALID)
  );

  board_rev1_clock_monitor #(
    .GATE_CYCLES(65535), .EXP_MIN(18), .EXP_MAX(22), .GOOD_WINDOWS(2)
  ) u_sat (
    .CLK(CLK), .RESET(RESET), .MON_TOGGLE(sat_mon), .ENABLE(sat_en), .FAULT_CLR(1'b0),
    .READY(sat_ready), .FAULT(sat_fault), .COUNT(sat_count), .COUNT_VALID(sat_cv)
  );

  always #5 CLK = ~CLK;

  // One clock: outputs are sampled and inputs driven 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
    rel++;
    if (per != 0) begin
      if (ph == 0) mon = ~mon;
      ph = (ph + 1 >= per) ? 0 : ph + 1;
    end
    if (sat_tog) sat_mon = ~sat_mon;
  endtask

  task automatic test_reset();
    RESET = 1'b1; en = 1'b1; fclr = 1'b0; mon = 1'b0; per = 0;
    repeat (3) step();
    n_cmp++; if (READY !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", READY); end
    n_cmp++; if (FAULT !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", FAULT); end
    n_cmp++; if (COUNT !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", COUNT); end
    n_cmp++; if (COUNT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_cv: got %b want 0", COUNT_VALID); end
    en = 1'b0; RESET = 1'b0;
    step();
  endtask

  // Toggle every 5 cycles; the switch to period 4 at rel 200 lines up with window 3.
  task automatic test_lock();
    int cv_bad;
    cv_bad = 0;
    per = 5; ph = 0;
    repeat (10) step();
    en = 1'b1; rel = 0;
    while (rel < 201) begin
      if (rel == 199) begin per = 4; ph = 0; end
      step();
      if (rel == 101) begin
        n_cmp++; if (COUNT_VALID !== 1'b1) begin n_bad++; $display("FAIL lock_cv1: got %b want 1", COUNT_VALID); end
        n_cmp++; if (COUNT !== 16'd20) begin n_bad++; $display("FAIL lock_count1: got %0d want 20", COUNT); end
        n_cmp++; if (READY !== 1'b0) begin n_bad++; $display("FAIL lock_ready1: got %b want 0", READY); end
      end else if (rel == 200) begin
        n_cmp++; if (READY !== 1'b0) begin n_bad++; $display("FAIL lock_ready_pre: got %b want 0", READY); end
      end else if (rel == 201) begin
        n_cmp++; if (COUNT_VALID !== 1'b1) begin n_bad++; $display("FAIL lock_cv2: got %b want 1", COUNT_VALID); end
        n_cmp++; if (COUNT !== 16'd20) begin n_bad++; $display("FAIL lock_count2: got %0d want 20", COUNT); end
        n_cmp++; if (READY !== 1'b1) begin n_bad++; $display("FAIL lock_ready2: got %b want 1", READY); end
        n_cmp++; if (FAULT !== 1'b0) begin n_bad++; $display("FAIL lock_fault: got %b want 0", FAULT); end
      end else if (COUNT_VALID !== 1'b0) cv_bad++;
    end
    n_cmp++; if (cv_bad !== 0) begin n_bad++; $display("FAIL lock_stray_cv: got %0d want 0", cv_bad); end
  endtask

  task automatic test_out_of_range();
    while (rel < 301) begin
      if (rel == 299) begin per = 5; ph = 0; end
      step();
      if (rel == 300) begin
        n_cmp++; if (READY !== 1'b1) begin n_bad++; $display("FAIL oor_ready_pre: got %b want 1", READY); end
      end
    end
    n_cmp++; if (COUNT_VALID !== 1'b1) begin n_bad++; $display("FAIL oor_cv: got %b want 1", COUNT_VALID); end
    n_cmp++; if (COUNT !== 16'd25) begin n_bad++; $display("FAIL oor_count: got %0d want 25", COUNT); end
    n_cmp++; if (READY !== 1'b0) begin n_bad++; $display("FAIL oor_ready: got %b want 0", READY); end
    n_cmp++; if (FAULT !== 1'b1) begin n_bad++; $display("FAIL oor_fault: got %b want 1", FAULT); end
  endtask

  task automatic test_fault_clear();
    fclr = 1'b1;
    step();
    fclr = 1'b0;
    n_cmp++; if (FAULT !== 1'b0) begin n_bad++; $display("FAIL clr_fault: got %b want 0", FAULT); end
    while (rel < 501) begin
      if (rel == 499) begin per = 4; ph = 0; end
      step();
      if (rel == 401) begin
        n_cmp++; if (COUNT !== 16'd20) begin n_bad++; $display("FAIL clr_count1: got %0d want 20", COUNT); end
        n_cmp++; if (READY !== 1'b0) begin n_bad++; $display("FAIL clr_ready1: got %b want 0", READY); end
      end
    end
    n_cmp++; if (COUNT_VALID !== 1'b1) begin n_bad++; $display("FAIL clr_cv2: got %b want 1", COUNT_VALID); end
    n_cmp++; if (READY !== 1'b1) begin n_bad++; $display("FAIL clr_ready2: got %b want 1", READY); end
    n_cmp++; if (FAULT !== 1'b0) begin n_bad++; $display("FAIL clr_fault2: got %b want 0", FAULT); end
  endtask

  task automatic test_clear_collision();
    while (rel < 600) begin
      if (rel == 599) begin per = 5; ph = 0; end
      step();
    end
    n_cmp++; if (READY !== 1'b1) begin n_bad++; $display("FAIL coll_ready_pre: got %b want 1", READY); end
    fclr = 1'b1;
    step();
    fclr = 1'b0;
    n_cmp++; if (COUNT_VALID !== 1'b1) begin n_bad++; $display("FAIL coll_cv: got %b want 1", COUNT_VALID); end
    n_cmp++; if (COUNT !== 16'd25) begin n_bad++; $display("FAIL coll_count: got %0d want 25", COUNT); end
    n_cmp++; if (FAULT !== 1'b1) begin n_bad++; $display("FAIL coll_fault: got %b want 1", FAULT); end
    step();
    n_cmp++; if (FAULT !== 1'b1) begin n_bad++; $display("FAIL coll_fault_hold: got %b want 1", FAULT); end
  endtask

  task automatic test_disable();
    int cv_bad;
    int seen;
    cv_bad = 0;
    seen = 0;
    while (rel < 851) begin
      step();
      if (rel == 801) begin
        n_cmp++; if (READY !== 1'b1) begin n_bad++; $display("FAIL dis_relock: got %b want 1", READY); end
      end
    end
    en = 1'b0;
    step();
    n_cmp++; if (READY !== 1'b0) begin n_bad++; $display("FAIL dis_ready: got %b want 0", READY); end
    n_cmp++; if (COUNT !== 16'd20) begin n_bad++; $display("FAIL dis_count: got %0d want 20", COUNT); end
    n_cmp++; if (FAULT !== 1'b1) begin n_bad++; $display("FAIL dis_fault_kept: got %b want 1", FAULT); end
    repeat (80) begin
      step();
      if (COUNT_VALID !== 1'b0) cv_bad++;
    end
    n_cmp++; if (cv_bad !== 0) begin n_bad++; $display("FAIL dis_stray_cv: got %0d want 0", cv_bad); end
    en = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (COUNT_VALID === 1'b1) begin seen = i; break; end
    end
    n_cmp++; if (seen !== 101) begin n_bad++; $display("FAIL dis_reenable_latency: got %0d want 101", seen); end
    n_cmp++; if (COUNT !== 16'd20) begin n_bad++; $display("FAIL dis_reenable_count: got %0d want 20", COUNT); end
  endtask

  task automatic test_reset_mid_window();
    int cv_bad;
    cv_bad = 0;
    repeat (30) step();
    RESET = 1'b1; fclr = 1'b0;
    step();
    RESET = 1'b0;
    n_cmp++; if (COUNT !== 16'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", COUNT); end
    n_cmp++; if (FAULT !== 1'b0) begin n_bad++; $display("FAIL mid_rst_fault: got %b want 0", FAULT); end
    repeat (100) begin
      step();
      if (COUNT_VALID !== 1'b0) cv_bad++;
    end
    n_cmp++; if (cv_bad !== 0) begin n_bad++; $display("FAIL mid_rst_stray_cv: got %0d want 0", cv_bad); end
    step();
    n_cmp++; if (COUNT_VALID !== 1'b1) begin n_bad++; $display("FAIL mid_rst_restart_cv: got %b want 1", COUNT_VALID); end
  endtask

  task automatic test_saturation();
    int seen;
    seen = 0;
    sat_tog = 1'b1;
    repeat (5) step();
    sat_en = 1'b1;
    for (int i = 1; i <= 65600; i++) begin
      step();
      if (sat_cv === 1'b1) begin seen = i; break; end
    end
    n_cmp++; if (seen !== 65536) begin n_bad++; $display("FAIL sat_latency: got %0d want 65536", seen); end
    n_cmp++; if (sat_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_count: got %h want ffff", sat_count); end
    n_cmp++; if (sat_ready !== 1'b0) begin n_bad++; $display("FAIL sat_ready: got %b want 0", sat_ready); end
    sat_tog = 1'b0;
    sat_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_out_of_range();
    test_fault_clear();
    test_clear_collision();
    test_disable();
    test_reset_mid_window();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_rev1_clock_monitor.md
BOARD_REV1_CLOCK_MONITOR -- requirements
Module: board_rev1_clock_monitor

Interface
REQ-001 Parameter GATE_CYCLES, default 1074, SHALL set the measurement window length in CLK cycles (10 us at 107.4 MHz); legal range 2..65535.
REQ-002 Parameter EXP_MIN, default 1300, SHALL be the lowest in-range edge count per window.
REQ-003 Parameter EXP_MAX, default 1390, SHALL be the highest in-range edge count per window.
REQ-004 Parameter GOOD_WINDOWS, default 4, SHALL be the number of consecutive in-range windows needed to lock; legal range 1..15.
REQ-005 CLK  in  1  single clock of the block (CLK_BASE domain); all logic on its rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 MON_TOGGLE  in  1  asynchronous toggle from the monitored clock domain; each level change is one edge.
REQ-008 ENABLE  in  1  level; 1 runs measurement, 0 holds the block idle.
REQ-009 FAULT_CLR  in  1  one-cycle pulse that clears the sticky FAULT flag.
REQ-010 READY  out  1  monitored clock verified in range (registered).
REQ-011 FAULT  out  1  sticky flag: a locked clock left its range.
REQ-012 COUNT  out  16  edge count of the last completed window.
REQ-013 COUNT_VALID  out  1  one-cycle pulse when COUNT updates.

Function
REQ-014 MON_TOGGLE SHALL pass through a 2-flop synchronizer plus one history flop; edge = sync2 XOR hist; an input change is counted 3 CLK cycles later.
REQ-015 States SHALL be IDLE, ACQUIRE and LOCKED; READY SHALL be 1 only in LOCKED.
REQ-016 IDLE: gate counter, edge counter and good counter held at 0; ENABLE=1 moves to ACQUIRE next cycle, and the first window starts in that cycle.
REQ-017 Window: gate counter runs 0..GATE_CYCLES-1 and wraps to 0 with no idle gap; every edge asserted during any of those GATE_CYCLES cycles, including the last, SHALL count toward that window.
REQ-018 Edge counter SHALL saturate at 16'hFFFF and never wrap.
REQ-019 In the cycle after a window's last cycle, COUNT SHALL hold that window's total and COUNT_VALID SHALL be 1 for exactly that cycle; the edge counter restarts at 0, or at 1 if an edge occurs in that cycle.
REQ-020 In-range SHALL mean EXP_MIN <= total <= EXP_MAX, compared unsigned at 16 bits.
REQ-021 ACQUIRE: in-range window increments the good counter; when it reaches GOOD_WINDOWS, the state is LOCKED in the COUNT_VALID cycle; out-of-range window clears the good counter and the state stays ACQUIRE.
REQ-022 LOCKED: in-range window keeps LOCKED; out-of-range window moves to ACQUIRE, clears the good counter, and sets FAULT; READY and FAULT change in the COUNT_VALID cycle.
REQ-023 FAULT SHALL stay set until FAULT_CLR=1 or RESET; if a FAULT set and FAULT_CLR occur in the same cycle, set wins.
REQ-024 ENABLE=0 in any state SHALL force IDLE next cycle, abort the current window with no COUNT_VALID, and drop READY; COUNT and FAULT SHALL be retained.
REQ-025 An out-of-range window in ACQUIRE SHALL NOT set FAULT.

Reset
REQ-026 RESET=1 SHALL force IDLE, READY=0, FAULT=0, COUNT=0, COUNT_VALID=0, clear all counters and load the synchronizer flops with 0; RESET overrides every other input in that cycle.
REQ-027 RESET asserted mid-window SHALL discard the partial count with no COUNT_VALID pulse.

Verification
Bench parameters: GATE_CYCLES=100, EXP_MIN=18, EXP_MAX=22, GOOD_WINDOWS=2.
REQ-028 ENABLE=1, MON_TOGGLE toggles every 5 cycles -> COUNT=20 on each COUNT_VALID; READY=1 in the 2nd COUNT_VALID cycle; FAULT=0.
REQ-029 Locked, then toggle every 4 cycles -> next window COUNT=25; READY 1->0 and FAULT 0->1 in that COUNT_VALID cycle.
REQ-030 FAULT=1, then FAULT_CLR pulse with the in-range 5-cycle toggle restored -> FAULT=0 next cycle; READY re-asserts after 2 good windows.
REQ-031 FAULT_CLR pulsed in the same cycle a locked out-of-range window ends -> FAULT=1 after that cycle.
REQ-032 ENABLE dropped at gate cycle 50 -> no COUNT_VALID, READY=0, COUNT keeps its prior value; re-enable -> first COUNT_VALID exactly 101 cycles later.
REQ-033 MON_TOGGLE toggles every cycle with GATE_CYCLES=65535 -> COUNT=16'hFFFF (saturated), READY=0.
